ssm_tile_streamer: RTL
======================

SSM_TILE_STREAMER -- requirements
Module: ssm_tile_streamer

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning the element width in bits.
REQ-002 The block SHALL have parameter N_TILE, default 16, meaning elements per tile.
REQ-003 The block SHALL have parameter N_TOTAL, default 128, meaning the state length; TILES = N_TOTAL/N_TILE, default 8.
REQ-004 The block SHALL have parameter TIMEOUT, default 256, meaning the maximum number of WAIT_Y cycles before an error.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have the following ports, each given as name, direction, width and meaning:
- clk, in, 1, sole clock; all logic on the rising edge.
- rst, in, 1, synchronous active-high reset.
- wr_en_i, in, 1, vector buffer write strobe.
- wr_sel_i, in, 2, buffer select: 0=B, 1=C, 2=hprev, 3=ignored.
- wr_addr_i, in, clog2(N_TOTAL), element index.
- wr_data_i, in, DW, element value.
- start_i, in, 1, begin one token.
- dt_i, dA_i, x_i, D_i, in, DW each, scalars.
- busy_o, out, 1, high when not IDLE.
- tile_valid_o, out, 1, tile offered.
- tile_ready_i, in, 1, downstream accepts the tile.
- B_tile_o, C_tile_o, hprev_tile_o, out, N_TILE*DW each, tile buses.
- dt_o, dA_o, x_o, D_o, out, DW each, latched scalars.
- y_final_i, in, DW, returned result.
- y_final_valid_i, in, 1, result strobe.
- y_o, out, DW, captured result.
- done_o, out, 1, one-cycle completion pulse.
- err_o, out, 1, error flag for the last token.

Function
REQ-007 The block SHALL implement an FSM with states IDLE, STREAM, WAIT_Y and DONE.
REQ-008 In IDLE, a buffer write SHALL occur on wr_en_i=1 with wr_sel_i<3, storing wr_data_i at wr_addr_i.
- Writes in any other state SHALL be ignored.
- An out-of-range address (>=N_TOTAL) SHALL be ignored.
REQ-009 IDLE->STREAM SHALL occur on start_i=1, with the following actions in the same edge:
- Latch dt_i, dA_i, x_i and D_i into dt_o, dA_o, x_o and D_o.
- Clear the tile index, err_o and y_o.
REQ-010 start_i SHALL be ignored outside IDLE.
REQ-011 In STREAM, tile_valid_o SHALL be 1, first asserted the cycle after start_i is accepted.
REQ-012 For current tile index t, bits [DW*j +: DW] of each tile bus SHALL equal buffer element t*N_TILE+j, for j in 0..N_TILE-1.
REQ-013 While tile_valid_o=1 and tile_ready_i=0, all tile buses and scalars SHALL stay stable.
REQ-014 A transfer SHALL occur on any cycle with tile_valid_o=1 and tile_ready_i=1, and SHALL increment t.
- With tile_ready_i held high, one tile SHALL transfer per cycle (II=1).
- Back-to-back transfers SHALL need no idle cycle.
REQ-015 The transfer of tile TILES-1 SHALL move the FSM to WAIT_Y; tile_valid_o SHALL be 0 from the next cycle on.
REQ-016 In WAIT_Y, a cycle counter SHALL run from 0.
- y_final_valid_i=1 SHALL capture y_final_i into y_o and move the FSM to DONE.
- If the counter reaches TIMEOUT-1 without y_final_valid_i, the block SHALL set err_o=1, keep y_o=0 and move to DONE.
REQ-017 y_final_valid_i=1 in STREAM SHALL be a protocol error: set err_o=1, deassert tile_valid_o next cycle, move to DONE, and leave y_o unchanged at 0.
REQ-018 y_final_valid_i in IDLE or DONE SHALL be ignored.
REQ-019 DONE SHALL last exactly one cycle with done_o=1 and SHALL then return to IDLE.
REQ-020 y_o and err_o SHALL hold until the next accepted start_i.
REQ-021 busy_o SHALL be 1 in STREAM, WAIT_Y and DONE.
REQ-022 Buffer contents SHALL persist across tokens, so repeated starts without rewriting SHALL resend identical tiles.

Reset
REQ-023 While rst=1, the block SHALL hold the following reset values:
- FSM=IDLE.
- tile_valid_o, done_o, err_o and busy_o = 0.
- y_o, dt_o, dA_o, x_o, D_o and the tile index = 0.
REQ-024 rst SHALL NOT clear the buffer contents.
REQ-025 rst asserted mid-STREAM or mid-WAIT_Y SHALL abort the token with no done_o pulse.

Verification
REQ-026 Load-and-stream: write B[k]=k, C[k]=0x100+k and hprev[k]=0x200+k for k=0..127, set start_i=1 with dt_i=0x3C00, and hold tile_ready_i=1.
- Required: 8 consecutive valid cycles.
- Tile 3 lane 5 SHALL read B=0x0035, C=0x0135 and hprev=0x0235.
- dt_o SHALL be 0x3C00.
REQ-027 Backpressure: tile_ready_i toggles 0,0,1 repeatedly.
- Required: each tile is held stable for 3 cycles.
- All 8 tiles are sent in order, with no duplicates or skips.
REQ-028 Result: after the last tile, y_final_valid_i=1 and y_final_i=0x4A12 five cycles later.
- Required: y_o=0x4A12, a done_o pulse of one cycle, err_o=0, then IDLE.
REQ-029 Timeout: no y_final_valid_i after streaming, with TIMEOUT=256.
- Required: done_o pulses after 256 WAIT_Y cycles, with err_o=1 and y_o=0.
REQ-030 Illegal events:
- y_final_valid_i during tile 2 SHALL give err_o=1 and done_o.
- start_i and wr_en_i while busy SHALL have no effect, confirmed by buffer readback on the next token.
REQ-031 Reset mid-stream: rst=1 for 1 cycle after tile 4.
- Required: all outputs are at reset values and there is no done_o.
- The next start_i resends tile 0 with the preserved buffer data.

Source files
------------

// File: rtl/ssm_tile_streamer.sv
// ssm_tile_streamer: stores B, C and hprev state vectors and streams them out as
// fixed-size tiles with latched scalars for one SSM token, then waits for the result.
// Latency: first tile is offered the cycle after start_i; tiles advance at one per cycle (II=1).
// Backpressure: tile_valid_o/tile_ready_i handshake; tiles and scalars hold while ready is low.
// Ports: clk/rst (sync, active-high); wr_* write port (IDLE only); start_i + dt/dA/x/D scalars;
//        tile_valid_o/tile_ready_i with B/C/hprev tile buses; y_final_* result return;
//        y_o, done_o, err_o, busy_o status.
module ssm_tile_streamer #(
  parameter int DW      = 16,
  parameter int N_TILE  = 16,
  parameter int N_TOTAL = 128,
  parameter int TIMEOUT = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en_i,
  input  logic [1:0]                  wr_sel_i,
  input  logic [$clog2(N_TOTAL)-1:0]  wr_addr_i,
  input  logic [DW-1:0]               wr_data_i,
  input  logic                        start_i,
  input  logic [DW-1:0]               dt_i,
  input  logic [DW-1:0]               dA_i,
  input  logic [DW-1:0]               x_i,
  input  logic [DW-1:0]               D_i,
  output logic                        busy_o,
  output logic                        tile_valid_o,
  input  logic                        tile_ready_i,
  output logic [N_TILE*DW-1:0]        B_tile_o,
  output logic [N_TILE*DW-1:0]        C_tile_o,
  output logic [N_TILE*DW-1:0]        hprev_tile_o,
  output logic [DW-1:0]               dt_o,
  output logic [DW-1:0]               dA_o,
  output logic [DW-1:0]               x_o,
  output logic [DW-1:0]               D_o,
  input  logic [DW-1:0]               y_final_i,
  input  logic                        y_final_valid_i,
  output logic [DW-1:0]               y_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int TILES = N_TOTAL / N_TILE;
  localparam int AW    = $clog2(N_TOTAL);
  localparam int TW    = (TILES > 1) ? $clog2(TILES) : 1;
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_WAIT_Y = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [TW-1:0] tile_idx;
  logic [CW-1:0] wait_cnt;

  // Vector buffers deliberately have no reset: contents survive rst and tokens.
  logic [DW-1:0] b_mem     [N_TOTAL];
  logic [DW-1:0] c_mem     [N_TOTAL];
  logic [DW-1:0] hprev_mem [N_TOTAL];

  logic addr_ok;
  logic wr_ok;
  logic xfer;
  logic last_tile;
  logic wait_expired;

  assign addr_ok      = ({1'b0, wr_addr_i} < (AW+1)'(N_TOTAL));
  assign wr_ok        = !rst && (state_q == S_IDLE) && wr_en_i && (wr_sel_i != 2'd3) && addr_ok;
  assign xfer         = (state_q == S_STREAM) && tile_ready_i;
  assign last_tile    = (tile_idx == TW'(TILES - 1));
  assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));

  // ---------------- buffer write ----------------
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      case (wr_sel_i)
        2'd0:    b_mem[wr_addr_i]     <= wr_data_i;
        2'd1:    c_mem[wr_addr_i]     <= wr_data_i;
        2'd2:    hprev_mem[wr_addr_i] <= wr_data_i;
        default: ;
      endcase
    end
  end

  // ---------------- tile read: lane j of tile t is element t*N_TILE+j ----------------
  for (genvar j = 0; j < N_TILE; j++) begin : g_lane
    logic [AW-1:0] rd_addr;
    assign rd_addr                  = AW'(tile_idx) * AW'(N_TILE) + AW'(j);
    assign B_tile_o[DW*j +: DW]     = b_mem[rd_addr];
    assign C_tile_o[DW*j +: DW]     = c_mem[rd_addr];
    assign hprev_tile_o[DW*j +: DW] = hprev_mem[rd_addr];
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_STREAM;
      // A result arriving while tiles are still going out is a protocol error.
      S_STREAM: begin
        if (y_final_valid_i)        state_d = S_DONE;
        else if (xfer && last_tile) state_d = S_WAIT_Y;
      end
      S_WAIT_Y: if (y_final_valid_i || wait_expired) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_o       = (state_q != S_IDLE);
    tile_valid_o = (state_q == S_STREAM);
    done_o       = (state_q == S_DONE);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_idx <= '0;
      wait_cnt <= '0;
      dt_o     <= '0;
      dA_o     <= '0;
      x_o      <= '0;
      D_o      <= '0;
      y_o      <= '0;
      err_o    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            dt_o     <= dt_i;
            dA_o     <= dA_i;
            x_o      <= x_i;
            D_o      <= D_i;
            tile_idx <= '0;
            y_o      <= '0;
            err_o    <= 1'b0;
          end
        end
        S_STREAM: begin
          // Keep the wait counter at zero so WAIT_Y always starts counting from 0.
          wait_cnt <= '0;
          if (y_final_valid_i) err_o    <= 1'b1;
          else if (xfer)       tile_idx <= tile_idx + 1'b1;
        end
        S_WAIT_Y: begin
          // A result on the final counted cycle still wins over the timeout.
          if (y_final_valid_i)   y_o      <= y_final_i;
          else if (wait_expired) err_o    <= 1'b1;
          else                   wait_cnt <= wait_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
